// File: rtl/seven_segment_monitor.sv
// rtl/seven_segment_monitor.sv - segment bus monitor: sync, glitch filter, decode, sequence check, watchdog
module seven_segment_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 2047
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    output logic [3:0] digit_out,
    output logic       digit_valid,
    output logic       invalid,
    output logic       seq_error,
    output logic       timeout,
    output logic [7:0] err_count
);

    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [STAB_W-1:0] STAB_MAX   = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]   WD_EXPIRED = WD_W'(TIMEOUT);

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        TRACK      = 1'b1
    } state_t;

    logic [6:0]        sync1_q, sync2_q;
    logic [6:0]        cand_q, cand_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [6:0]        acc_q, acc_d;
    state_t            state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [3:0]        digit_q, digit_d;
    logic              valid_q, valid_d;
    logic              invalid_q, invalid_d;
    logic              seqerr_q, seqerr_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        errcnt_q, errcnt_d;

    logic              accept;
    logic              expire;
    logic              dec_legal;
    logic [3:0]        dec_digit;
    logic [3:0]        next_digit;

    always_comb begin
        dec_legal = 1'b1;
        dec_digit = 4'd0;
        case (cand_q)
            7'h3F: dec_digit = 4'd0;
            7'h06: dec_digit = 4'd1;
            7'h5B: dec_digit = 4'd2;
            7'h4F: dec_digit = 4'd3;
            7'h66: dec_digit = 4'd4;
            7'h6D: dec_digit = 4'd5;
            7'h7D: dec_digit = 4'd6;
            7'h07: dec_digit = 4'd7;
            7'h7F: dec_digit = 4'd8;
            7'h6F: dec_digit = 4'd9;
            default: dec_legal = 1'b0;
        endcase
    end

    // A candidate held long enough is accepted even if sync2 moves on this same cycle.
    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        acc_d  = acc_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            stab_d = '0;
        end else if (stab_q < STAB_MAX) begin
            stab_d = stab_q + STAB_W'(1);
        end
        accept = (stab_q == STAB_MAX) && (cand_q != acc_q);
        if (accept) begin
            acc_d = cand_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        digit_d    = digit_q;
        valid_d    = valid_q;
        invalid_d  = invalid_q;
        seqerr_d   = 1'b0;
        timeout_d  = timeout_q;
        errcnt_d   = errcnt_q;
        next_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        expire     = (state_q == TRACK) && (wd_q == WD_LAST);
        if (accept) begin
            wd_d = '0;
            if (dec_legal) begin
                if ((state_q == TRACK) && (dec_digit != next_digit)) begin
                    seqerr_d = 1'b1;
                    if (errcnt_q != 8'hFF) begin
                        errcnt_d = errcnt_q + 8'd1;
                    end
                end
                digit_d   = dec_digit;
                valid_d   = 1'b1;
                invalid_d = 1'b0;
                timeout_d = 1'b0;
                state_d   = TRACK;
            end else begin
                invalid_d = 1'b1;
                valid_d   = 1'b0;
                state_d   = WAIT_FIRST;
            end
        end else if (expire) begin
            timeout_d = 1'b1;
            valid_d   = 1'b0;
            state_d   = WAIT_FIRST;
            wd_d      = WD_EXPIRED;
        end else if (state_q == TRACK) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cand_q    <= '0;
            stab_q    <= '0;
            acc_q     <= '0;
            state_q   <= WAIT_FIRST;
            wd_q      <= '0;
            digit_q   <= '0;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
            seqerr_q  <= 1'b0;
            timeout_q <= 1'b0;
            errcnt_q  <= '0;
        end else begin
            sync1_q   <= seg_in;
            sync2_q   <= sync1_q;
            cand_q    <= cand_d;
            stab_q    <= stab_d;
            acc_q     <= acc_d;
            state_q   <= state_d;
            wd_q      <= wd_d;
            digit_q   <= digit_d;
            valid_q   <= valid_d;
            invalid_q <= invalid_d;
            seqerr_q  <= seqerr_d;
            timeout_q <= timeout_d;
            errcnt_q  <= errcnt_d;
        end
    end

    assign digit_out   = digit_q;
    assign digit_valid = valid_q;
    assign invalid     = invalid_q;
    assign seq_error   = seqerr_q;
    assign timeout     = timeout_q;
    assign err_count   = errcnt_q;

endmodule

// File: tb/tb_seven_segment_monitor.sv
// tb/tb_seven_segment_monitor.sv - directed scoreboard bench for seven_segment_monitor
module tb_seven_segment_monitor;

    localparam int STAB = 4;
    localparam int TMO  = 2047;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg_in = 7'h00;
    logic [3:0] digit_out;
    logic       digit_valid, invalid, seq_error, timeout;
    logic [7:0] err_count;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    typedef struct {
        string      tag;
        logic [3:0] d;
        logic       v;
        logic       inv;
        logic       se;
        logic       to;
        logic [7:0] ec;
    } exp_t;

    exp_t sb[$];

    seven_segment_monitor #(.STABLE_CYCLES(STAB), .TIMEOUT(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .seg_in(seg_in),
        .digit_out(digit_out),
        .digit_valid(digit_valid),
        .invalid(invalid),
        .seq_error(seq_error),
        .timeout(timeout),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (seq_error === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] d, input logic v, input logic inv,
                        input logic se, input logic to, input logic [7:0] ec);
        exp_t e;
        e.tag = tag; e.d = d; e.v = v; e.inv = inv; e.se = se; e.to = to; e.ec = ec;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, ".digit"}, 32'(digit_out), 32'(e.d));
            chk({e.tag, ".valid"}, 32'(digit_valid), 32'(e.v));
            chk({e.tag, ".invalid"}, 32'(invalid), 32'(e.inv));
            chk({e.tag, ".seq_error"}, 32'(seq_error), 32'(e.se));
            chk({e.tag, ".timeout"}, 32'(timeout), 32'(e.to));
            chk({e.tag, ".err_count"}, 32'(err_count), 32'(e.ec));
        end
    endtask

    // Drive a pattern, expect outputs on edge STAB+3, then check the seq_error pulse has ended.
    task automatic step(input string tag, input logic [6:0] pat, input int hold,
                        input logic [3:0] d, input logic v, input logic inv,
                        input logic se, input logic to, input logic [7:0] ec);
        @(negedge clk);
        seg_in = pat;
        push(tag, d, v, inv, se, to, ec);
        repeat (STAB + 3) @(negedge clk);
        check_pop();
        @(negedge clk);
        chk({tag, ".se_end"}, 32'(seq_error), 32'd0);
        repeat (hold - STAB - 4) @(negedge clk);
    endtask

    initial begin
        #1;
        push("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_pop();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        @(negedge clk);
        seg_in = 7'h3F;
        push("first0", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (STAB + 2) @(negedge clk);
        chk("first0.latency", 32'(digit_valid), 32'd0);
        @(negedge clk);
        check_pop();
        repeat (3) @(negedge clk);

        step("seq1", 7'h06, 20, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step("seq2", 7'h5B, 20, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step("seq3", 7'h4F, 20, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step("seq4", 7'h66, 20, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step("seq5", 7'h6D, 20, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step("seq6", 7'h7D, 20, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step("seq7", 7'h07, 20, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step("seq8", 7'h7F, 20, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step("seq9", 7'h6F, 20, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step("wrap0", 7'h3F, 20, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        step("skip_a", 7'h06, 20, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step("skip_b", 7'h4F, 20, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
        step("back2", 7'h5B, 20, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);

        @(negedge clk);
        seg_in = 7'h7F;
        repeat (3) @(negedge clk);
        seg_in = 7'h5B;
        push("glitch", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        repeat (20) @(negedge clk);
        check_pop();
        chk("glitch.pulses", 32'(pulses), 32'd2);

        step("illegal", 7'h7C, 20, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
        step("recover0", 7'h3F, 20, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);

        step("wd_start", 7'h06, STAB + 4, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        repeat (TMO - 2) @(negedge clk);
        push("wd_before", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        check_pop();
        @(negedge clk);
        push("wd_expire", 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
        check_pop();
        repeat (10) @(negedge clk);
        push("wd_held", 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
        check_pop();

        step("wd_clear", 7'h5B, 20, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);

        @(negedge clk);
        seg_in = 7'h4F;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        push("mid_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_pop();
        @(negedge clk);
        reset = 1'b0;
        push("post_reset", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (STAB + 3) @(negedge clk);
        check_pop();
        repeat (3) @(negedge clk);

        chk("total_pulses", 32'(pulses), 32'd2);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
